// File: rtl/divu_pkg.sv
// divu_pkg: shared definitions for the sequential unsigned divider.
//   state_t   - FSM states of divu_seq (IDLE, RUN, DONE)
//   cnt_width - width of the iteration counter for a dividend of n bits
package divu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter must hold the value n itself, hence n+1 distinct codes.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/subu.sv
// subu: combinational unsigned subtractor.
//   a    [L1-1:0]  minuend
//   b    [L2-1:0]  subtrahend, zero-extended to the minuend width
//   diff [L1:0]    a - b; diff[L1] is the borrow (set when a < b)
module subu #(
    parameter int L1 = 8,
    parameter int L2 = 8
) (
    input  logic [L1-1:0] a,
    input  logic [L2-1:0] b,
    output logic [L1:0]   diff
);

    assign diff = {1'b0, a} - (L1 + 1)'(b);

endmodule

// File: rtl/divu_seq.sv
// divu_seq: sequential unsigned restoring divider, one quotient bit per clock.
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - request a division (ignored while busy)
//   in1      - dividend [L1-1:0], captured on accepted start
//   in2      - divisor  [L2-1:0], captured on accepted start
//   busy     - high while iterations are running
//   done     - one-cycle pulse when quot/rem/div_zero are valid
//   quot     - quotient  [L1-1:0], loaded only on entry to DONE
//   rem      - remainder [L2-1:0], loaded only on entry to DONE
//   div_zero - set together with done when the divisor was zero
module divu_seq
    import divu_pkg::*;
#(
    parameter int L1 = 8,
    parameter int L2 = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [L1-1:0] in1,
    input  logic [L2-1:0] in2,
    output logic          busy,
    output logic          done,
    output logic [L1-1:0] quot,
    output logic [L2-1:0] rem,
    output logic          div_zero
);

    localparam int CW = cnt_width(L1);

    state_t        state;
    logic [L1-1:0] dvd;      // dividend, consumed MSB first
    logic [L2-1:0] dvs;      // captured divisor
    logic [L2:0]   pr;       // partial remainder
    logic [L1-1:0] q;        // quotient shift register
    logic [CW-1:0] cnt;

    logic [L2:0]   shifted;
    logic [L2+1:0] diff;
    logic          borrow;
    logic [L2:0]   pr_next;
    logic [L1-1:0] q_next;

    // pr is always below the divisor, so its shift into L2+1 bits never overflows.
    assign shifted = (pr << 1) | (L2 + 1)'(dvd[L1-1]);

    subu #(
        .L1(L2 + 1),
        .L2(L2)
    ) u_subu (
        .a   (shifted),
        .b   (dvs),
        .diff(diff)
    );

    assign borrow  = diff[L2+1];
    assign pr_next = borrow ? shifted : diff[L2:0];
    assign q_next  = (q << 1) | L1'(!borrow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            div_zero <= 1'b0;
            dvd      <= '0;
            dvs      <= '0;
            pr       <= '0;
            q        <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        dvd <= in1;
                        dvs <= in2;
                        pr  <= '0;
                        q   <= '0;
                        cnt <= CW'(L1);
                        if (in2 == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            quot     <= '1;
                            rem      <= '0;
                        end else begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            div_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    dvd <= dvd << 1;
                    pr  <= pr_next;
                    q   <= q_next;
                    cnt <= cnt - CW'(1);
                    // Last iteration: publish results from the same-cycle next values.
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        quot  <= q_next;
                        rem   <= pr_next[L2-1:0];
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
